// File: rtl/rs_multi_issue_pkg.sv
// Shared types for the multi-issue reservation station: physical tags, RS rows, FU classes.
package rs_multi_issue_pkg;

  localparam int unsigned RS_SIZE_DEF = 16;
  localparam int unsigned NUM_FU_DEF  = 5;
  localparam int unsigned PREG_W      = 6;
  localparam int unsigned PHYS_W      = PREG_W + 1;

  // MSB is the ready bit, low PREG_W bits are the physical register index.
  typedef logic [PHYS_W-1:0] PHYS_REG;

  localparam logic [PREG_W-1:0] DUMMY_REG = '0;

  typedef enum logic [1:0] {FuAlu, FuMult, FuMem, FuBranch} FU_CLASS_T;

  typedef struct packed {
    logic [7:0]        op;
    FU_CLASS_T         fu;
    logic [PREG_W-1:0] dest;
    PHYS_REG           t1;
    PHYS_REG           t2;
  } RS_ROW_T;

  localparam int unsigned ROW_W = $bits(RS_ROW_T);

  // Issue slot to FU class map: two ALUs, then MULT, MEM, BRANCH.
  function automatic FU_CLASS_T fu_class_of(input int unsigned slot);
    case (slot)
      0, 1:    return FuAlu;
      2:       return FuMult;
      3:       return FuMem;
      default: return FuBranch;
    endcase
  endfunction

endpackage

// File: rtl/rs_multi_issue_select.sv
// One issue picker: chooses a single entry from eligible & ~exclude as a one-hot grant.
// With RS_AGE_ORDER_EN the oldest entry wins (ties to lowest index), else the lowest index.
module rs_multi_issue_select #(
  parameter int unsigned RS_SIZE = 16
`ifdef RS_AGE_ORDER_EN
  , parameter int unsigned AGE_W = 4
`endif
) (
  input  logic               en,
  input  logic [RS_SIZE-1:0] eligible,
  input  logic [RS_SIZE-1:0] exclude,
`ifdef RS_AGE_ORDER_EN
  input  logic [RS_SIZE*AGE_W-1:0] ages,
`endif
  output logic [RS_SIZE-1:0] grant
);

  logic [RS_SIZE-1:0] cand;
  logic               found;
`ifdef RS_AGE_ORDER_EN
  logic [AGE_W-1:0]   best_age;
`endif

  always_comb begin
    cand  = eligible & ~exclude;
    grant = '0;
    found = 1'b0;
`ifdef RS_AGE_ORDER_EN
    best_age = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      // Strict compare keeps the lowest index on equal ages.
      if (en && cand[i] && (!found || ages[i*AGE_W +: AGE_W] > best_age)) begin
        found    = 1'b1;
        best_age = ages[i*AGE_W +: AGE_W];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
`else
    for (int i = 0; i < RS_SIZE; i++) begin
      if (en && cand[i] && !found) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/rs_multi_issue.sv
// Reservation station with N-wide dispatch, M-wide CDB wakeup and one issue slot per FU.
// Optional age-ordered select is enabled by defining RS_AGE_ORDER_EN.
module rs_multi_issue
  import rs_multi_issue_pkg::*;
#(
  parameter int unsigned RS_SIZE    = RS_SIZE_DEF,
  parameter int unsigned DISPATCH_W = 2,
  parameter int unsigned CDB_W      = 2,
  parameter int unsigned NUM_FU     = NUM_FU_DEF
`ifdef RS_AGE_ORDER_EN
  , parameter int unsigned AGE_W    = 4
`endif
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           squash,
  input  logic [DISPATCH_W-1:0]          dispatch_valid,
  input  logic [DISPATCH_W*ROW_W-1:0]    inst_in,
  input  logic [CDB_W-1:0]               CDB_valid,
  input  logic [CDB_W*PHYS_W-1:0]        CDB_tag,
  input  logic [NUM_FU-1:0]              fu_ready,
  output logic [RS_SIZE*ROW_W-1:0]       rs_table_out,
  output logic [NUM_FU-1:0]              issue_valid,
  output logic [NUM_FU*ROW_W-1:0]        issue_row,
  output logic [$clog2(NUM_FU+1)-1:0]    issue_cnt,
  output logic [$clog2(RS_SIZE+1)-1:0]   free_cnt,
  output logic                           rs_full
);

  localparam int unsigned CNT_W  = $clog2(NUM_FU+1);
  localparam int unsigned FREE_W = $clog2(RS_SIZE+1);

  RS_ROW_T               table_q [RS_SIZE];
  RS_ROW_T               table_d [RS_SIZE];
  logic [RS_SIZE-1:0]    busy_q, busy_d;
  RS_ROW_T               issue_row_q [NUM_FU];
  RS_ROW_T               issue_row_d [NUM_FU];
  logic [NUM_FU-1:0]     issue_valid_q, issue_valid_d;

  RS_ROW_T               inst_row [DISPATCH_W];
  RS_ROW_T               nrow;
  logic [PREG_W-1:0]     cdb_idx [CDB_W];
  logic [CDB_W-1:0]      unused_cdb_rdy;
  logic [NUM_FU-1:0][RS_SIZE-1:0] slot_grant;
  logic [RS_SIZE-1:0]    avail;
  logic                  placed;

`ifdef RS_AGE_ORDER_EN
  logic [AGE_W-1:0]         age_q [RS_SIZE];
  logic [AGE_W-1:0]         age_d [RS_SIZE];
  logic [RS_SIZE*AGE_W-1:0] age_flat;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) age_flat[i*AGE_W +: AGE_W] = age_q[i];
  end
`endif

  always_comb begin
    for (int d = 0; d < DISPATCH_W; d++) inst_row[d] = RS_ROW_T'(inst_in[d*ROW_W +: ROW_W]);
    for (int c = 0; c < CDB_W; c++) begin
      cdb_idx[c]        = CDB_tag[c*PHYS_W +: PREG_W];
      unused_cdb_rdy[c] = CDB_tag[c*PHYS_W + PREG_W];
    end
  end

  // Select chain: each slot excludes everything granted to lower-numbered slots.
  for (genvar j = 0; j < NUM_FU; j++) begin : g_slot
    logic [RS_SIZE-1:0] elig, excl, grant, taken;

    always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
        elig[i] = busy_q[i] && table_q[i].t1[PREG_W] && table_q[i].t2[PREG_W] &&
                  (table_q[i].fu == fu_class_of(j));
      end
    end

    if (j == 0) begin : g_head
      assign excl = '0;
    end else begin : g_tail
      assign excl = g_slot[j-1].taken;
    end

    rs_multi_issue_select #(
      .RS_SIZE (RS_SIZE)
`ifdef RS_AGE_ORDER_EN
      , .AGE_W (AGE_W)
`endif
    ) u_select (
      .en       (enable & fu_ready[j]),
      .eligible (elig),
      .exclude  (excl),
`ifdef RS_AGE_ORDER_EN
      .ages     (age_flat),
`endif
      .grant    (grant)
    );

    assign taken         = excl | grant;
    assign slot_grant[j] = grant;
  end

  always_comb begin
    table_d       = table_q;
    busy_d        = busy_q;
    issue_valid_d = '0;
    nrow          = '0;
    placed        = 1'b0;
    for (int j = 0; j < NUM_FU; j++) issue_row_d[j] = '0;
`ifdef RS_AGE_ORDER_EN
    for (int i = 0; i < RS_SIZE; i++) begin
      age_d[i] = (busy_q[i] && age_q[i] != '1) ? age_q[i] + AGE_W'(1) : age_q[i];
    end
`endif

    // Wakeup of resident entries applies regardless of enable.
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int c = 0; c < CDB_W; c++) begin
        if (busy_q[i] && CDB_valid[c]) begin
          if (cdb_idx[c] == table_q[i].t1[PREG_W-1:0]) table_d[i].t1[PREG_W] = 1'b1;
          if (cdb_idx[c] == table_q[i].t2[PREG_W-1:0]) table_d[i].t2[PREG_W] = 1'b1;
        end
      end
    end

    for (int j = 0; j < NUM_FU; j++) begin
      issue_valid_d[j] = |slot_grant[j];
      for (int i = 0; i < RS_SIZE; i++) begin
        if (slot_grant[j][i]) begin
          issue_row_d[j] = table_q[i];
          busy_d[i]      = 1'b0;
          table_d[i]     = '0;
`ifdef RS_AGE_ORDER_EN
          age_d[i]       = '0;
`endif
        end
      end
    end

    // Only entries free before this edge are allocatable; entries issued now reopen next cycle.
    avail = ~busy_q;
    for (int d = 0; d < DISPATCH_W; d++) begin
      nrow   = inst_row[d];
      placed = 1'b0;
      for (int c = 0; c < CDB_W; c++) begin
        if (CDB_valid[c] && cdb_idx[c] == nrow.t1[PREG_W-1:0]) nrow.t1[PREG_W] = 1'b1;
        if (CDB_valid[c] && cdb_idx[c] == nrow.t2[PREG_W-1:0]) nrow.t2[PREG_W] = 1'b1;
      end
      if (nrow.t1[PREG_W-1:0] == DUMMY_REG) nrow.t1[PREG_W] = 1'b1;
      if (nrow.t2[PREG_W-1:0] == DUMMY_REG) nrow.t2[PREG_W] = 1'b1;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (enable && dispatch_valid[d] && !placed && avail[i]) begin
          placed     = 1'b1;
          avail[i]   = 1'b0;
          table_d[i] = nrow;
          busy_d[i]  = 1'b1;
`ifdef RS_AGE_ORDER_EN
          age_d[i]   = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      busy_q        <= '0;
      issue_valid_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) table_q[i] <= '0;
      for (int j = 0; j < NUM_FU; j++) issue_row_q[j] <= '0;
`ifdef RS_AGE_ORDER_EN
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
`endif
    end else begin
      busy_q        <= busy_d;
      issue_valid_q <= issue_valid_d;
      table_q       <= table_d;
      issue_row_q   <= issue_row_d;
`ifdef RS_AGE_ORDER_EN
      age_q         <= age_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) rs_table_out[i*ROW_W +: ROW_W] = table_q[i];
    for (int j = 0; j < NUM_FU; j++) issue_row[j*ROW_W +: ROW_W] = issue_row_q[j];
    issue_valid = issue_valid_q;
    issue_cnt   = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (issue_valid_q[j]) issue_cnt = issue_cnt + CNT_W'(1);
    end
    free_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!busy_q[i]) free_cnt = free_cnt + FREE_W'(1);
    end
    rs_full = (free_cnt == '0);
  end

endmodule

// File: tb/tb_rs_multi_issue.sv
// Directed, table-driven bench for rs_multi_issue plus hand sequences for fill/squash and ordering.
module tb_rs_multi_issue;
  import rs_multi_issue_pkg::*;

  typedef logic [4:0][7:0] ops_t;

  typedef struct {
    logic       en;
    logic [1:0] dv;
    RS_ROW_T    r0;
    RS_ROW_T    r1;
    logic [1:0] cv;
    PHYS_REG    t0;
    PHYS_REG    t1;
    logic [4:0] fr;
    logic [4:0] eiv;
    int         efree;
    ops_t       eop;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset, enable, squash;
  logic [1:0]       dispatch_valid;
  RS_ROW_T [1:0]    inst_in;
  logic [1:0]       cdb_valid;
  PHYS_REG [1:0]    cdb_tag;
  logic [4:0]       fu_ready;
  RS_ROW_T [15:0]   rs_table_out;
  logic [4:0]       issue_valid;
  RS_ROW_T [4:0]    issue_row;
  logic [2:0]       issue_cnt;
  logic [4:0]       free_cnt;
  logic             rs_full;

  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  rs_multi_issue dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .squash         (squash),
    .dispatch_valid (dispatch_valid),
    .inst_in        (inst_in),
    .CDB_valid      (cdb_valid),
    .CDB_tag        (cdb_tag),
    .fu_ready       (fu_ready),
    .rs_table_out   (rs_table_out),
    .issue_valid    (issue_valid),
    .issue_row      (issue_row),
    .issue_cnt      (issue_cnt),
    .free_cnt       (free_cnt),
    .rs_full        (rs_full)
  );

  always #5 clock = ~clock;

  function automatic RS_ROW_T mkrow(input logic [7:0] op, input FU_CLASS_T fu,
                                    input logic [5:0] a, input logic ra,
                                    input logic [5:0] b, input logic rb);
    RS_ROW_T r;
    r.op   = op;
    r.fu   = fu;
    r.dest = op[5:0];
    r.t1   = {ra, a};
    r.t2   = {rb, b};
    return r;
  endfunction

  function automatic RS_ROW_T rdy(input logic [7:0] op, input FU_CLASS_T fu);
    return mkrow(op, fu, 6'd1, 1'b1, 6'd2, 1'b1);
  endfunction

  function automatic ops_t ops5(input logic [7:0] o0, o1, o2, o3, o4);
    return {o4, o3, o2, o1, o0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] dv, input RS_ROW_T r0, input RS_ROW_T r1,
                       input logic [1:0] cv, input PHYS_REG t0, input PHYS_REG t1,
                       input logic [4:0] fr);
    enable         = en;
    dispatch_valid = dv;
    inst_in[0]     = r0;
    inst_in[1]     = r1;
    cdb_valid      = cv;
    cdb_tag[0]     = t0;
    cdb_tag[1]     = t1;
    fu_ready       = fr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [4:0] eiv, input int efree,
                           input ops_t eop);
    ops_t act;
    for (int j = 0; j < 5; j++) act[j] = issue_row[j].op;
    chk($sformatf("%s.issue_valid", tag), 64'(issue_valid), 64'(eiv));
    chk($sformatf("%s.issue_cnt", tag), 64'(issue_cnt), 64'($countones(eiv)));
    chk($sformatf("%s.free_cnt", tag), 64'(free_cnt), 64'(efree));
    chk($sformatf("%s.rs_full", tag), 64'(rs_full), 64'(efree == 0));
    chk($sformatf("%s.issue_ops", tag), 64'(act), 64'(eop));
  endtask

  task automatic add(input logic en, input logic [1:0] dv, input RS_ROW_T r0, input RS_ROW_T r1,
                     input logic [1:0] cv, input PHYS_REG t0, input PHYS_REG t1,
                     input logic [4:0] fr, input logic [4:0] eiv, input int efree,
                     input ops_t eop);
    vec_t v;
    v.en = en; v.dv = dv; v.r0 = r0; v.r1 = r1; v.cv = cv; v.t0 = t0; v.t1 = t1; v.fr = fr;
    v.eiv = eiv; v.efree = efree; v.eop = eop;
    vq.push_back(v);
  endtask

  initial begin
    ops_t z;
    z = '0;

    // Reset with dispatch requests present: everything must be dropped.
    reset  = 1'b1;
    squash = 1'b0;
    drive(1'b1, 2'b11, rdy(8'd90, FuAlu), rdy(8'd91, FuAlu), 2'b00, '0, '0, 5'b11111);
    tick();
    tick();
    check_out("reset", 5'b0, 16, z);
    chk("reset.table", 64'(rs_table_out != '0), 64'd0);
    reset = 1'b0;

    // Two ALU rows dispatched, issued together on both ALU slots one edge later.
    add(1, 2'b11, rdy(8'd1, FuAlu), rdy(8'd2, FuAlu), 2'b00, '0, '0, 5'b11111, 5'b00000, 14, z);
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b00011, 16, ops5(1, 2, 0, 0, 0));
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b00000, 16, z);
    // T1=p5 pending, woken by CDB slot 1, issued the cycle after the wakeup edge.
    add(1, 2'b01, mkrow(8'd3, FuAlu, 6'd5, 0, 6'd9, 1), '0, 2'b00, '0, '0, 5'b11111,
        5'b00000, 15, z);
    add(1, 2'b00, '0, '0, 2'b10, '0, {1'b0, 6'd5}, 5'b11111, 5'b00000, 15, z);
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b00001, 16, ops5(3, 0, 0, 0, 0));
    // T2=p7 broadcast in the dispatch cycle: stored ready.
    add(1, 2'b01, mkrow(8'd4, FuAlu, 6'd1, 1, 6'd7, 0), '0, 2'b01, {1'b0, 6'd7}, '0,
        5'b11111, 5'b00000, 15, z);
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b00001, 16, ops5(4, 0, 0, 0, 0));
    // enable=0 drops dispatch and freezes issue.
    add(0, 2'b01, rdy(8'd5, FuAlu), '0, 2'b00, '0, '0, 5'b11111, 5'b00000, 16, z);
    add(1, 2'b01, rdy(8'd6, FuAlu), '0, 2'b00, '0, '0, 5'b11111, 5'b00000, 15, z);
    add(0, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b00000, 15, z);
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b00001, 16, ops5(6, 0, 0, 0, 0));
    // Slot 0 busy: second ALU slot takes the op; slot 0 row reads zero.
    add(1, 2'b01, rdy(8'd7, FuAlu), '0, 2'b00, '0, '0, 5'b11111, 5'b00000, 15, z);
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11110, 5'b00010, 16, ops5(0, 7, 0, 0, 0));
    // Class routing to MULT and MEM slots.
    add(1, 2'b11, rdy(8'd8, FuMult), rdy(8'd9, FuMem), 2'b00, '0, '0, 5'b11111,
        5'b00000, 14, z);
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b01100, 16, ops5(0, 0, 8, 9, 0));
    // Issue and dispatch in the same cycle: new rows go to entries free before the edge.
    add(1, 2'b11, rdy(8'd10, FuAlu), rdy(8'd11, FuAlu), 2'b00, '0, '0, 5'b11111,
        5'b00000, 14, z);
    add(1, 2'b11, rdy(8'd12, FuAlu), rdy(8'd13, FuAlu), 2'b00, '0, '0, 5'b11111,
        5'b00011, 14, ops5(10, 11, 0, 0, 0));
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b00011, 16, ops5(12, 13, 0, 0, 0));
    // Wakeup while disabled; CDB ready bit set but ignored.
    add(1, 2'b01, mkrow(8'd14, FuAlu, 6'd12, 0, 6'd2, 1), '0, 2'b00, '0, '0, 5'b11111,
        5'b00000, 15, z);
    add(0, 2'b00, '0, '0, 2'b01, {1'b1, 6'd12}, '0, 5'b11111, 5'b00000, 15, z);
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b00001, 16, ops5(14, 0, 0, 0, 0));
    // Branch slot, and DUMMY_REG operands that arrive not-ready but count as ready.
    add(1, 2'b01, rdy(8'd15, FuBranch), '0, 2'b00, '0, '0, 5'b11111, 5'b00000, 15, z);
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b10000, 16, ops5(0, 0, 0, 0, 15));
    add(1, 2'b01, mkrow(8'd16, FuAlu, 6'd0, 0, 6'd0, 0), '0, 2'b00, '0, '0, 5'b11111,
        5'b00000, 15, z);
    add(1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111, 5'b00001, 16, ops5(16, 0, 0, 0, 0));

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].en, vq[k].dv, vq[k].r0, vq[k].r1, vq[k].cv, vq[k].t0, vq[k].t1, vq[k].fr);
      tick();
      check_out($sformatf("vec%0d", k), vq[k].eiv, vq[k].efree, vq[k].eop);
    end

    // Fill all 16 entries with issue blocked, overflow is dropped, then squash.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'b11, rdy(8'(32 + 2*k), FuAlu), rdy(8'(33 + 2*k), FuAlu), 2'b00, '0, '0,
            5'b00000);
      tick();
    end
    check_out("fill", 5'b0, 0, z);
    drive(1'b1, 2'b11, rdy(8'd99, FuAlu), rdy(8'd98, FuAlu), 2'b00, '0, '0, 5'b00000);
    tick();
    check_out("overflow", 5'b0, 0, z);
    chk("overflow.entry0", 64'(rs_table_out[0].op), 64'd32);
    chk("overflow.entry15", 64'(rs_table_out[15].op), 64'd47);
    drive(1'b1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b11111);
    tick();
    check_out("drain", 5'b00011, 2, ops5(32, 33, 0, 0, 0));
    squash = 1'b1;
    drive(1'b1, 2'b11, rdy(8'd97, FuAlu), rdy(8'd96, FuAlu), 2'b11, {1'b0, 6'd1}, '0, 5'b11111);
    tick();
    squash = 1'b0;
    check_out("squash", 5'b0, 16, z);
    chk("squash.table", 64'(rs_table_out != '0), 64'd0);

    // Older MULT at entry 5 versus newer MULT at entry 0 on the single MULT slot.
    drive(1'b1, 2'b11, rdy(8'd20, FuAlu), rdy(8'd21, FuAlu), 2'b00, '0, '0, 5'b00000);
    tick();
    drive(1'b1, 2'b11, rdy(8'd22, FuAlu), rdy(8'd23, FuAlu), 2'b00, '0, '0, 5'b00000);
    tick();
    drive(1'b1, 2'b11, rdy(8'd24, FuAlu), rdy(8'd25, FuMult), 2'b00, '0, '0, 5'b00000);
    tick();
    check_out("age.load", 5'b0, 10, z);
    drive(1'b1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b00011);
    tick();
    check_out("age.alu0", 5'b00011, 12, ops5(20, 21, 0, 0, 0));
    tick();
    check_out("age.alu1", 5'b00011, 14, ops5(22, 23, 0, 0, 0));
    tick();
    check_out("age.alu2", 5'b00001, 15, ops5(24, 0, 0, 0, 0));
    drive(1'b1, 2'b01, rdy(8'd26, FuMult), '0, 2'b00, '0, '0, 5'b00000);
    tick();
    check_out("age.newmult", 5'b0, 14, z);
    drive(1'b1, 2'b00, '0, '0, 2'b00, '0, '0, 5'b00100);
    tick();
`ifdef RS_AGE_ORDER_EN
    check_out("age.first", 5'b00100, 15, ops5(0, 0, 25, 0, 0));
    tick();
    check_out("age.second", 5'b00100, 16, ops5(0, 0, 26, 0, 0));
`else
    check_out("age.first", 5'b00100, 15, ops5(0, 0, 26, 0, 0));
    tick();
    check_out("age.second", 5'b00100, 16, ops5(0, 0, 25, 0, 0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
